// File: rtl/ysyx_24100005_pkg.sv
// Shared definitions for the ysyx_24100005 key/value lookup blocks.
// A table entry is a key followed by its data, packed MSB-first.
package ysyx_24100005_pkg;

  function automatic int pair_len(input int key_len, input int data_len);
    return key_len + data_len;
  endfunction

endpackage

// File: rtl/ysyx_24100005_mux_key_with_default_if.sv
// Lookup bus: key, table and fallback toward the mux; results back to the consumer.
interface ysyx_24100005_mux_key_with_default_if
  import ysyx_24100005_pkg::*;
#(
  parameter int NR_KEY   = 2,
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 1
);
  localparam int PAIR_LEN = pair_len(KEY_LEN, DATA_LEN);

  logic [KEY_LEN-1:0]         key;
  logic [DATA_LEN-1:0]        default_out;
  logic [NR_KEY*PAIR_LEN-1:0] lut;
  logic [DATA_LEN-1:0]        out;
  logic                       hit;
  logic [DATA_LEN-1:0]        out_q;
  logic                       hit_q;

  modport master (
    output key, default_out, lut,
    input  out, hit, out_q, hit_q
  );

  modport slave (
    input  key, default_out, lut,
    output out, hit, out_q, hit_q
  );
endinterface

// File: rtl/ysyx_24100005_mux_key_core.sv
// Unpacks the key/data table, compares every entry against the key and
// OR-reduces the data of all matching entries.
module ysyx_24100005_mux_key_core
  import ysyx_24100005_pkg::*;
#(
  parameter int NR_KEY   = 2,
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 1
) (
  input  logic [KEY_LEN-1:0]                                key,
  input  logic [NR_KEY*pair_len(KEY_LEN, DATA_LEN)-1:0]     lut,
  output logic [DATA_LEN-1:0]                               or_data,
  output logic                                              hit
);
  localparam int PAIR_LEN = pair_len(KEY_LEN, DATA_LEN);

  logic [NR_KEY-1:0]   match;
  logic [DATA_LEN-1:0] masked [NR_KEY];

  genvar gi;
  generate
    for (gi = 0; gi < NR_KEY; gi++) begin : g_entry
      logic [KEY_LEN-1:0]  entry_key;
      logic [DATA_LEN-1:0] entry_data;

      assign entry_key  = lut[gi*PAIR_LEN+DATA_LEN +: KEY_LEN];
      assign entry_data = lut[gi*PAIR_LEN +: DATA_LEN];
      assign match[gi]  = (key == entry_key);
      // AND-mask rather than a mux so an unknown match bit propagates as-is.
      assign masked[gi] = entry_data & {DATA_LEN{match[gi]}};
    end
  endgenerate

  always_comb begin
    or_data = '0;
    for (int i = 0; i < NR_KEY; i++) begin
      or_data = or_data | masked[i];
    end
  end

  assign hit = |match;

endmodule

// File: rtl/ysyx_24100005_mux_key_with_default.sv
// Key lookup with fallback value: combinational result plus a registered copy
// (asynchronously cleared) for pipelined consumers.
module ysyx_24100005_mux_key_with_default
  import ysyx_24100005_pkg::*;
#(
  parameter int NR_KEY   = 2,
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 1
) (
  input  logic                                       clk,
  input  logic                                       rst,
  ysyx_24100005_mux_key_with_default_if.slave        bus
);
  logic [DATA_LEN-1:0] or_data;
  logic                hit_d;
  logic [DATA_LEN-1:0] out_d;
  logic [DATA_LEN-1:0] out_q;
  logic                hit_q;

  ysyx_24100005_mux_key_core #(
    .NR_KEY  (NR_KEY),
    .KEY_LEN (KEY_LEN),
    .DATA_LEN(DATA_LEN)
  ) u_core (
    .key    (bus.key),
    .lut    (bus.lut),
    .or_data(or_data),
    .hit    (hit_d)
  );

  assign out_d = hit_d ? or_data : bus.default_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
      hit_q <= 1'b0;
    end else begin
      out_q <= out_d;
      hit_q <= hit_d;
    end
  end

  assign bus.out   = out_d;
  assign bus.hit   = hit_d;
  assign bus.out_q = out_q;
  assign bus.hit_q = hit_q;

endmodule

// File: tb/tb_ysyx_24100005_mux_key_with_default.sv
// Self-checking bench: three configurations (1x1x1, 3x7x4 opcode table, 4x3x4 sweep).
module tb_ysyx_24100005_mux_key_with_default;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_24100005_mux_key_with_default_if #(.NR_KEY(1), .KEY_LEN(1), .DATA_LEN(1)) if1 ();
  ysyx_24100005_mux_key_with_default_if #(.NR_KEY(3), .KEY_LEN(7), .DATA_LEN(4)) if3 ();
  ysyx_24100005_mux_key_with_default_if #(.NR_KEY(4), .KEY_LEN(3), .DATA_LEN(4)) if4 ();

  ysyx_24100005_mux_key_with_default #(.NR_KEY(1), .KEY_LEN(1), .DATA_LEN(1))
    dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  ysyx_24100005_mux_key_with_default #(.NR_KEY(3), .KEY_LEN(7), .DATA_LEN(4))
    dut3 (.clk(clk), .rst(rst), .bus(if3.slave));
  ysyx_24100005_mux_key_with_default #(.NR_KEY(4), .KEY_LEN(3), .DATA_LEN(4))
    dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

  localparam logic [32:0] LUT3_NORM = {7'h13, 4'h4, 7'h23, 4'h2, 7'h03, 4'h1};
  localparam logic [32:0] LUT3_DUP  = {7'h7F, 4'h0, 7'h03, 4'h8, 7'h03, 4'h1};

  typedef struct {
    int         sel;      // 0: 1x1x1, 1: opcode table, 2: duplicate-key table
    logic [6:0] key;
    logic [3:0] exp_out;
    logic       exp_hit;
  } vec_t;

  vec_t vecs [8];
  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Reference: OR of data over entries whose key equals the lookup key, else default.
  function automatic logic [4:0] ref_lookup(input int keys[4], input int datas[4],
                                            input int k, input int dflt);
    int acc = 0;
    bit any = 0;
    for (int i = 0; i < 4; i++) begin
      if (keys[i] == k) begin
        acc = acc | datas[i];
        any = 1;
      end
    end
    return any ? {1'b1, 4'(acc)} : {1'b0, 4'(dflt)};
  endfunction

  initial begin
    int keys[4];
    int datas[4];
    int dflt;
    logic [4:0] exp;

    vecs[0] = '{0, 7'h00, 4'h1, 1'b1};
    vecs[1] = '{0, 7'h01, 4'h0, 1'b0};
    vecs[2] = '{1, 7'h23, 4'h2, 1'b1};
    vecs[3] = '{1, 7'h33, 4'hF, 1'b0};
    vecs[4] = '{1, 7'h03, 4'h1, 1'b1};
    vecs[5] = '{1, 7'h13, 4'h4, 1'b1};
    vecs[6] = '{2, 7'h03, 4'h9, 1'b1};
    vecs[7] = '{2, 7'h23, 4'hF, 1'b0};

    if1.key = 1'b0; if1.default_out = 1'b0; if1.lut = 2'b01;
    if3.key = 7'h0;  if3.default_out = 4'hF; if3.lut = LUT3_NORM;
    if4.key = 3'h0;  if4.default_out = 4'h0; if4.lut = '0;

    // Reset state, including across a clock edge while rst is held.
    #2;
    chk("rst out_q dut1", 32'(if1.out_q), 0);
    chk("rst hit_q dut3", 32'(if3.hit_q), 0);
    chk("rst out_q dut3", 32'(if3.out_q), 0);
    @(negedge clk);
    chk("rst held out_q dut1", 32'(if1.out_q), 0);
    chk("rst held hit_q dut1", 32'(if1.hit_q), 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (vecs[i].sel == 0) begin
        if1.key = vecs[i].key[0];
        #1;
        chk($sformatf("vec%0d out", i), 32'(if1.out), 32'(vecs[i].exp_out));
        chk($sformatf("vec%0d hit", i), 32'(if1.hit), 32'(vecs[i].exp_hit));
      end else begin
        if3.lut = (vecs[i].sel == 1) ? LUT3_NORM : LUT3_DUP;
        if3.key = vecs[i].key;
        #1;
        chk($sformatf("vec%0d out", i), 32'(if3.out), 32'(vecs[i].exp_out));
        chk($sformatf("vec%0d hit", i), 32'(if3.hit), 32'(vecs[i].exp_hit));
      end
    end

    // Registered path: capture, then hold between edges.
    if3.lut = LUT3_NORM;
    @(negedge clk); if3.key = 7'h13;
    @(negedge clk);
    chk("reg out_q 13", 32'(if3.out_q), 32'h4);
    chk("reg hit_q 13", 32'(if3.hit_q), 1);
    #2; if3.key = 7'h33; #1;
    chk("reg hold out_q", 32'(if3.out_q), 32'h4);
    chk("reg comb out 33", 32'(if3.out), 32'hF);
    @(negedge clk);
    chk("reg out_q 33", 32'(if3.out_q), 32'hF);
    chk("reg hit_q 33", 32'(if3.hit_q), 0);

    // Asynchronous reset mid-operation.
    if3.key = 7'h13;
    @(negedge clk);
    chk("pre-rst out_q", 32'(if3.out_q), 32'h4);
    #2; rst = 1'b1; #1;
    chk("async rst out_q", 32'(if3.out_q), 0);
    chk("async rst hit_q", 32'(if3.hit_q), 0);
    chk("async rst comb out", 32'(if3.out), 32'h4);
    if3.key = 7'h23; #1;
    chk("rst comb tracks", 32'(if3.out), 32'h2);
    @(negedge clk);
    chk("rst hold out_q", 32'(if3.out_q), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post-rst out_q", 32'(if3.out_q), 32'h2);
    chk("post-rst hit_q", 32'(if3.hit_q), 1);

    // Exhaustive key sweep over random tables.
    for (int r = 0; r < 20; r++) begin
      for (int e = 0; e < 4; e++) begin
        keys[e]  = int'($urandom_range(0, 7));
        datas[e] = int'($urandom_range(0, 15));
        if4.lut[e*7 +: 7] = {3'(keys[e]), 4'(datas[e])};
      end
      dflt = int'($urandom_range(0, 15));
      if4.default_out = 4'(dflt);
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if4.key = 3'(k);
        #1;
        exp = ref_lookup(keys, datas, k, dflt);
        chk($sformatf("sweep r%0d k%0d out", r, k), 32'(if4.out), 32'(exp[3:0]));
        chk($sformatf("sweep r%0d k%0d hit", r, k), 32'(if4.hit), 32'(exp[4]));
        @(negedge clk);
        chk($sformatf("sweep r%0d k%0d out_q", r, k), 32'(if4.out_q), 32'(exp[3:0]));
        chk($sformatf("sweep r%0d k%0d hit_q", r, k), 32'(if4.hit_q), 32'(exp[4]));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
